// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: scan states, blank glyph, hex glyph table.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package seg7_pkg;

  // Scan state; the encoding value doubles as the digit index being driven.
  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } scan_state_t;

  // All segments dark, in active-high gfedcba form (polarity is applied at the pins).
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Hex nibble to active-high {g,f,e,d,c,b,a}; letters b and d are lower case.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0:    glyph = 7'b0111111;
      4'h1:    glyph = 7'b0000110;
      4'h2:    glyph = 7'b1011011;
      4'h3:    glyph = 7'b1001111;
      4'h4:    glyph = 7'b1100110;
      4'h5:    glyph = 7'b1101101;
      4'h6:    glyph = 7'b1111101;
      4'h7:    glyph = 7'b0000111;
      4'h8:    glyph = 7'b1111111;
      4'h9:    glyph = 7'b1101111;
      4'hA:    glyph = 7'b1110111;
      4'hB:    glyph = 7'b1111100;
      4'hC:    glyph = 7'b0111001;
      4'hD:    glyph = 7'b1011110;
      4'hE:    glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-high seven-segment pattern.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the input continuously.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with refresh prescaler and tear-free staged loads.
// Latency: pins reflect the scan state one cycle after it changes; loads appear at the next frame boundary.
// Backpressure: none; load is always accepted and a later load overwrites an earlier pending one.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pcnt;
  logic          tick;
  logic          boundary;
  scan_state_t   state;

  logic [15:0] stg_value;
  logic [3:0]  stg_dp;
  logic        stg_blz;
  logic        pending;
  logic [15:0] disp_value;
  logic [3:0]  disp_dp;
  logic        disp_blz;

  logic [3:0]  nibble;
  logic        blank;
  logic [6:0]  seg_hex;
  logic [6:0]  seg_ah;
  logic [3:0]  an_ah;

  assign tick     = (pcnt == LAST);
  assign boundary = tick && (state == D3);

  // Prescaler: one tick every PRESCALE cycles paces the digit scan.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pcnt <= '0;
    else if (tick) pcnt <= '0;
    else pcnt <= pcnt + 1'b1;
  end

  // Digit scan FSM: rotates D0..D3, stepping once per tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= D0;
    end else if (tick) begin
      case (state)
        D0:      state <= D1;
        D1:      state <= D2;
        D2:      state <= D3;
        default: state <= D0;
      endcase
    end
  end

  // Staged load: capture into staging, promote to display only at a frame boundary (bypass if coincident).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stg_value  <= '0;
      stg_dp     <= '0;
      stg_blz    <= 1'b0;
      pending    <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blz   <= 1'b0;
    end else begin
      if (load) begin
        stg_value <= value;
        stg_dp    <= dp;
        stg_blz   <= blank_lz;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          disp_value <= value;
          disp_dp    <= dp;
          disp_blz   <= blank_lz;
        end else if (pending) begin
          disp_value <= stg_value;
          disp_dp    <= stg_dp;
          disp_blz   <= stg_blz;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Select the current digit's nibble and decide leading-zero blanking; digit0 is never blanked.
  always_comb begin
    nibble = disp_value[3:0];
    blank  = 1'b0;
    case (state)
      D0: nibble = disp_value[3:0];
      D1: begin
        nibble = disp_value[7:4];
        blank  = disp_blz && (disp_value[15:4] == 12'h000);
      end
      D2: begin
        nibble = disp_value[11:8];
        blank  = disp_blz && (disp_value[15:8] == 8'h00);
      end
      default: begin
        nibble = disp_value[15:12];
        blank  = disp_blz && (disp_value[15:12] == 4'h0);
      end
    endcase
  end

  seg7_hex_decoder u_dec (
    .nibble (nibble),
    .seg    (seg_hex)
  );

  assign seg_ah = blank ? SEG_OFF : seg_hex;
  assign an_ah  = 4'b0001 << state;

  // Output registers: polarity applied here so the pins are glitch-free; reset drives everything dark.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an         <= {4{ACTIVE_LOW}};
      seg        <= {7{ACTIVE_LOW}};
      dp_n       <= ACTIVE_LOW;
      frame_done <= 1'b0;
    end else begin
      an         <= an_ah ^ {4{ACTIVE_LOW}};
      seg        <= seg_ah ^ {7{ACTIVE_LOW}};
      dp_n       <= disp_dp[state] ^ ACTIVE_LOW;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (PRESCALE=4, ACTIVE_LOW=1) against a frame-arithmetic model.
// Latency: model predicts pin values after every rising edge from the edge count since reset release.
// Backpressure: not applicable.
module tb_seg7_scan_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  seg7_scan_driver #(.PRESCALE(4), .ACTIVE_LOW(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  // Active-high gfedcba glyphs for 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int errors = 0;
  int checks = 0;

  // Model: e = rising edges since reset release; 4 cycles per digit, 16 per frame.
  int          e;
  logic [15:0] m_dv, m_sv;
  logic [3:0]  m_dd, m_sd;
  logic        m_db, m_sb, m_pend;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp_n, exp_fd;

  task automatic model_reset();
    e = 0;
    m_dv = '0; m_dd = '0; m_db = 1'b0;
    m_sv = '0; m_sd = '0; m_sb = 1'b0;
    m_pend = 1'b0;
  endtask

  // Drive one cycle of inputs, advance one edge, predict the pins, update the display model.
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic b);
    int k;
    logic [3:0] nib;
    logic [3:0] onehot;
    logic blank;
    load = ld; value = v; dp = d; blank_lz = b;
    @(posedge clock);
    e++;
    k = ((e - 1) / 4) % 4;
    nib = 4'(m_dv >> (4 * k));
    blank = m_db && (k != 0) && ((m_dv >> (4 * k)) == 16'h0000);
    onehot = 4'b0001 << k;
    exp_an = ~onehot;
    exp_seg = blank ? 7'h7F : ~GLYPH[nib];
    exp_dp_n = ~m_dd[k];
    exp_fd = (e % 16 == 0);
    if (e % 16 == 0) begin
      if (ld) begin
        m_dv = v; m_dd = d; m_db = b;
      end else if (m_pend) begin
        m_dv = m_sv; m_dd = m_sd; m_db = m_sb;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_sv = v; m_sd = d; m_sb = b; m_pend = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      checks++;
      if ({an, seg, dp_n, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_off got an=%b seg=%b dp_n=%b fd=%b want 1111 1111111 1 0", an, seg, dp_n, frame_done);
      end
    end
    reset = 1'b1;
    model_reset();
    repeat (20) begin
      idle();
      checks++;
      if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dp_n, exp_fd}) begin
        errors++;
        $display("FAIL reset_release e=%0d got an=%b seg=%b dp_n=%b fd=%b want an=%b seg=%b dp_n=%b fd=%b",
                 e, an, seg, dp_n, frame_done, exp_an, exp_seg, exp_dp_n, exp_fd);
      end
    end
  endtask

  task automatic test_scan();
    int pulses;
    step(1'b1, 16'h1234, 4'b0000, 1'b0);
    while (e % 16 != 0) idle();
    pulses = 0;
    repeat (32) begin
      idle();
      if (frame_done) pulses++;
      checks++;
      if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dp_n, exp_fd}) begin
        errors++;
        $display("FAIL scan_1234 e=%0d got an=%b seg=%b dp_n=%b fd=%b want an=%b seg=%b dp_n=%b fd=%b",
                 e, an, seg, dp_n, frame_done, exp_an, exp_seg, exp_dp_n, exp_fd);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL frame_done_count got %0d want 2", pulses);
    end
  endtask

  task automatic test_midframe_load();
    while ((e / 4) % 4 != 1) idle();
    step(1'b1, 16'hABCD, 4'b0000, 1'b0);
    repeat (24) begin
      idle();
      checks++;
      if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dp_n, exp_fd}) begin
        errors++;
        $display("FAIL midframe_load e=%0d got an=%b seg=%b dp_n=%b fd=%b want an=%b seg=%b dp_n=%b fd=%b",
                 e, an, seg, dp_n, frame_done, exp_an, exp_seg, exp_dp_n, exp_fd);
      end
    end
  endtask

  task automatic test_back_to_back();
    while (e % 16 != 0) idle();
    step(1'b1, 16'h1111, 4'b0000, 1'b0);
    step(1'b1, 16'h2222, 4'b0000, 1'b0);
    while (e % 16 != 15) idle();
    repeat (18) begin
      idle();
      checks++;
      if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dp_n, exp_fd}) begin
        errors++;
        $display("FAIL latest_load_wins e=%0d got an=%b seg=%b want an=%b seg=%b", e, an, seg, exp_an, exp_seg);
      end
    end
    while (e % 16 != 15) idle();
    step(1'b1, 16'h5555, 4'b0000, 1'b0);
    repeat (17) begin
      idle();
      checks++;
      if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dp_n, exp_fd}) begin
        errors++;
        $display("FAIL boundary_bypass e=%0d got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                 e, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] vals [3] = '{16'h0050, 16'h0000, 16'h0000};
    logic [3:0]  dps  [3] = '{4'b0000, 4'b0000, 4'b0100};
    logic        blzs [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vals[i], dps[i], blzs[i]);
      repeat (36) begin
        idle();
        checks++;
        if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dp_n, exp_fd}) begin
          errors++;
          $display("FAIL blank_dp case=%0d e=%0d got an=%b seg=%b dp_n=%b want an=%b seg=%b dp_n=%b",
                   i, e, an, seg, dp_n, exp_an, exp_seg, exp_dp_n);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    while (e % 16 != 0) idle();
    step(1'b1, 16'h9876, 4'b1111, 1'b0);
    while (((e - 1) / 4) % 4 != 2) idle();
    reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp_n, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got an=%b seg=%b dp_n=%b fd=%b want 1111 1111111 1 0", an, seg, dp_n, frame_done);
    end
    @(posedge clock); #1;
    checks++;
    if ({an, seg, dp_n, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got an=%b seg=%b dp_n=%b fd=%b want 1111 1111111 1 0", an, seg, dp_n, frame_done);
    end
    reset = 1'b1;
    model_reset();
    repeat (40) begin
      idle();
      checks++;
      if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dp_n, exp_fd}) begin
        errors++;
        $display("FAIL pending_discarded e=%0d got an=%b seg=%b dp_n=%b fd=%b want an=%b seg=%b dp_n=%b fd=%b",
                 e, an, seg, dp_n, frame_done, exp_an, exp_seg, exp_dp_n, exp_fd);
      end
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      if ($urandom_range(0, 6) == 0) step(1'b1, 16'($urandom), 4'($urandom), 1'($urandom));
      else idle();
      checks++;
      if ({an, seg, dp_n, frame_done} !== {exp_an, exp_seg, exp_dp_n, exp_fd}) begin
        errors++;
        $display("FAIL random e=%0d got an=%b seg=%b dp_n=%b fd=%b want an=%b seg=%b dp_n=%b fd=%b",
                 e, an, seg, dp_n, frame_done, exp_an, exp_seg, exp_dp_n, exp_fd);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_midframe_load();
    test_back_to_back();
    test_blanking();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
